// File: rtl/sm_pkg.sv
// Shared definitions for the sequential divider: default operand width and FSM state type.
package sm_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider; the requester drives master, the divider is slave.
interface seq_divider_if
    import sm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 ready;
    logic                 done;
    logic                 error;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, ready, done, error
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, ready, done, error
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import sm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    localparam int RW = WIDTH + 1;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    assign shifted     = {rem_i, bit_i};
    assign divisor_ext = {2'b00, divisor_i};

    // The incoming remainder is always below the divisor, so the difference fits in WIDTH+1 bits.
    assign q_bit_o = (shifted >= divisor_ext);
    assign rem_o   = q_bit_o ? RW'(shifted - divisor_ext) : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
module seq_divider
    import sm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remain_q, remain_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [WIDTH:0]     step_rem;
    logic               step_q_bit;
    logic [WIDTH-1:0]   shift_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shift_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign shift_next = {shift_q[WIDTH-2:0], step_q_bit};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        remain_d  = remain_q;
        done_d    = 1'b0;
        error_d   = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                        done_d   = 1'b1;
                        error_d  = 1'b1;
                        quot_d   = '1;
                        remain_d = '1;
                    end else begin
                        state_d   = ST_BUSY;
                        cnt_d     = '0;
                        rem_d     = {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
                        shift_d   = bus.dividend[WIDTH-1:0];
                        divisor_d = bus.divisor;
                        error_d   = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                rem_d   = step_rem;
                shift_d = shift_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    quot_d   = shift_next;
                    remain_d = step_rem[WIDTH-1:0];
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            remain_q  <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = remain_q;

endmodule
